// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if
// Requester-side handshake bundle for spi_txn_arbiter.
//   req0/req1     : requester wants a byte sent (held until its grant)
//   tx0/tx1       : byte to transmit, stable while req is high
//   last0/last1   : this byte closes the burst (CS released afterwards)
//   grant0/grant1 : one-cycle pulse, tx/last captured
//   done0/done1   : one-cycle pulse, byte finished and rx_byte valid
//   rx_byte       : most recently received byte
//   busy          : arbiter is not idle
//   owner         : current or most recent grantee
// Modports: master = requester side, slave = arbiter side.
interface spi_txn_arbiter_if;
  logic       req0;
  logic [7:0] tx0;
  logic       last0;
  logic       grant0;
  logic       done0;
  logic       req1;
  logic [7:0] tx1;
  logic       last1;
  logic       grant1;
  logic       done1;
  logic [7:0] rx_byte;
  logic       busy;
  logic       owner;

  modport master (
    output req0, tx0, last0, req1, tx1, last1,
    input  grant0, done0, grant1, done1, rx_byte, busy, owner
  );

  modport slave (
    input  req0, tx0, last0, req1, tx1, last1,
    output grant0, done0, grant1, done1, rx_byte, busy, owner
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
// Shares one SPI Mode-0 master between two requesters with round-robin
// arbitration and multi-byte bursts (CS held low until the owner flags last).
// SCLK is derived from clk12MHz: one half-period is CLK_DIV clock cycles.
// Ports:
//   clk12MHz      : system clock, all logic on posedge
//   rst           : asynchronous, active-low reset
//   bus           : requester handshake bundle (spi_txn_arbiter_if.slave)
//   SPI_CS_OUT    : chip select, active-low
//   SPI_CLK_OUT   : SCLK, idles low
//   SPI_MOSI_OUT  : transmit data, MSB first
//   SPI_MISO_IN   : receive data, sampled on the SCLK rise
// Build option: define SPI_LOOPBACK_EN to sample the internal MOSI register
// instead of SPI_MISO_IN, so rx_byte echoes the transmitted byte.
module spi_txn_arbiter #(
  parameter int CLK_DIV = 6,
  parameter int CS_GAP  = 2
) (
  input  logic              clk12MHz,
  input  logic              rst,
  spi_txn_arbiter_if.slave  bus,
  output logic              SPI_CS_OUT,
  output logic              SPI_CLK_OUT,
  output logic              SPI_MOSI_OUT,
  input  logic              SPI_MISO_IN
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t     state;
  logic [7:0] div;
  logic [3:0] bit_cnt;
  logic [7:0] tx_sh;
  logic [7:0] shift_in;
  logic       last_q;
  logic       owner_q;
  logic       grant0_q, grant1_q, done0_q, done1_q;
  logic [7:0] rx_q;
  logic       cs_q, sclk_q, mosi_q;

  logic       tick;
  logic       miso_src;
  logic       req_any, winner, pick, take;
  logic [7:0] tx_sel;
  logic       last_sel;

  assign tick = (div == 8'(CLK_DIV - 1));

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = SPI_MISO_IN;
  // mosi_q still holds the bit being driven when SCLK rises
  assign miso_src    = mosi_q;
`else
  assign miso_src    = SPI_MISO_IN;
`endif

  // In IDLE either requester may win; in HOLD only the burst owner is served.
  always_comb begin
    req_any = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) winner = ~owner_q;
    else                      winner = bus.req1;
    pick = winner;
    take = 1'b0;
    if (state == IDLE) begin
      take = req_any;
    end else if (state == HOLD) begin
      pick = owner_q;
      take = owner_q ? bus.req1 : bus.req0;
    end
    tx_sel   = pick ? bus.tx1   : bus.tx0;
    last_sel = pick ? bus.last1 : bus.last0;
  end

  always_ff @(posedge clk12MHz or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      div      <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      shift_in <= '0;
      last_q   <= 1'b0;
      owner_q  <= 1'b1;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rx_q     <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      // Free-running divider; wrapping on tick makes it restart at 0 on
      // every state change that happens on a tick.
      div <= tick ? '0 : div + 8'd1;

      case (state)
        IDLE, HOLD: begin
          div     <= '0;
          bit_cnt <= '0;
          if (take) begin
            owner_q  <= pick;
            grant0_q <= ~pick;
            grant1_q <= pick;
            tx_sh    <= tx_sel;
            last_q   <= last_sel;
            cs_q     <= 1'b0;
            mosi_q   <= tx_sel[7];
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (tick) begin
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end

        // Even bit_cnt ends a low half-period (rise, sample MISO); odd
        // bit_cnt ends a high half-period (fall, next MOSI bit).
        SHIFT: begin
          if (tick) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (!bit_cnt[0]) begin
              sclk_q   <= 1'b1;
              shift_in <= {shift_in[6:0], miso_src};
            end else begin
              sclk_q <= 1'b0;
              if (bit_cnt == 4'd15) begin
                rx_q    <= shift_in;
                done0_q <= ~owner_q;
                done1_q <= owner_q;
                bit_cnt <= '0;
                if (last_q) begin
                  cs_q   <= 1'b1;
                  mosi_q <= 1'b0;
                  state  <= GAP;
                end else begin
                  state  <= HOLD;
                end
              end else begin
                mosi_q <= tx_sh[6];
                tx_sh  <= {tx_sh[6:0], 1'b0};
              end
            end
          end
        end

        // bit_cnt is reused to count deselected half-periods
        GAP: begin
          if (tick) begin
            if (bit_cnt == 4'(CS_GAP - 1)) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant0   = grant0_q;
  assign bus.grant1   = grant1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.rx_byte  = rx_q;
  assign bus.busy     = (state != IDLE);
  assign bus.owner    = owner_q;
  assign SPI_CS_OUT   = cs_q;
  assign SPI_CLK_OUT  = sclk_q;
  assign SPI_MOSI_OUT = mosi_q;

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Sequences SPI Mode-0 byte transfers and shares one SPI master (CS, SCLK, MOSI, MISO) between two requesters.
- Generates the SPI clock internally from clk12MHz and arbitrates round-robin.
- Supports multi-byte bursts: CS stays asserted until the owning requester flags the last byte.
- Sits between the top-level control FSMs (and LED diagnostics) and the SPI port pins.

Parameters:
- CLK_DIV, 6, clk12MHz cycles per SPI half-period (6 gives SCLK = 1 MHz); legal range 2..255.
- CS_GAP, 2, half-periods with CS deasserted between transactions; legal range 1..15.

Ports:
- clk12MHz  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 wants a byte sent; held until grant0.
- tx0  in  8  requester 0 transmit byte; stable while req0 is high.
- last0  in  1  requester 0: this byte ends the burst; sampled with tx0.
- grant0  out  1  one-cycle pulse: tx0/last0 captured.
- done0  out  1  one-cycle pulse: requester 0 byte complete, rx_byte valid.
- req1, tx1, last1, grant1, done1  same as above, for requester 1.
- rx_byte  out  8  last received byte; held until the next done pulse.
- busy  out  1  high in every state except IDLE.
- owner  out  1  index of the current or most recent grantee.
- SPI_CS_OUT  out  1  chip select, active-low.
- SPI_CLK_OUT  out  1  SCLK, idles low.
- SPI_MOSI_OUT  out  1  MSB-first data.
- SPI_MISO_IN  in  1  slave data, sampled on SCLK rise.

Behaviour:
- Reset (async, rst=0):
  - State IDLE; CS=1, SCLK=0, MOSI=0.
  - grant*/done*=0, rx_byte=0x00, busy=0.
  - owner=1, so req0 wins the first tie. Divider and bit counter cleared.
  - Reset asserted mid-transfer aborts immediately; no done pulse is issued.
- Tick: divider counts 0..CLK_DIV-1, runs only outside IDLE/HOLD, and restarts at 0 on every state entry. tick=1 on the terminal count.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - If any req, grant the winner; the winner is registered, and grant is pulsed on the first clock edge where req is seen.
  - Arbitration: only one requester -> it wins. Both -> the one not equal to owner wins.
  - On the grant cycle: capture tx/last, owner<=winner, CS<=0, MOSI<=tx[7], enter SETUP.
- SETUP: one half-period (CLK_DIV cycles), SCLK low, then enter SHIFT.
- SHIFT: 16 half-periods, 4-bit bit counter.
  - Odd half-period: SCLK<=1, sample MISO into shift_in LSB.
  - Even half-period: SCLK<=0, present the next MOSI bit.
  - After the 16th half-period (SCLK low): rx_byte<=shift_in, pulse done[owner].
  - Then go to GAP if the latched last=1, else HOLD.
- Byte timing: done occurs exactly 17*CLK_DIV cycles after grant.
- HOLD:
  - CS stays 0, SCLK 0, MOSI holds its last bit.
  - Only req[owner] is honoured. It is granted next cycle, captures tx/last, MOSI<=tx[7], enters SETUP.
  - The other requester waits, with no grant, however long HOLD lasts.
- GAP: CS=1, MOSI=0 for CS_GAP*CLK_DIV cycles, then IDLE. Requests are not granted during GAP.
- A requester deasserting req before grant withdraws cleanly, with no side effects.
- A grant and a done pulse never occur for the same requester in the same cycle.

Optional Feature:
- SPI_LOOPBACK_EN defined:
  - The MISO sample source is the internal MOSI register, not SPI_MISO_IN, so rx_byte equals the byte sent.
  - SPI_MISO_IN is ignored.
  - Pins still toggle normally.
- SPI_LOOPBACK_EN undefined: MISO is sampled from the pin as above.

Test Plan:
- Single byte: CLK_DIV=6, req0 with tx0=0xA5, last0=1, MISO model returns 0x3C.
  - grant0 1 cycle after req0 is seen; MOSI bits 1,0,1,0,0,1,0,1 on SCLK rises.
  - done0 at grant+102 cycles, rx_byte=0x3C.
  - CS high for 12 cycles, then busy=0.
- Tie after reset: req0 and req1 both asserted -> grant0 first. With both held, the next grant goes to requester 1; grants alternate 0,1,0,1.
- Burst: req1 sends 0x11 (last1=0), 0x22 (last1=0), 0x33 (last1=1), while req0 is held high throughout.
  - CS stays low across all three bytes; no grant0 until GAP completes.
  - Then grant0 is issued.
- Reset mid-SHIFT: assert rst after 5 SCLK rises.
  - CS=1, SCLK=0, MOSI=0 asynchronously; no done pulse; rx_byte=0x00.
  - After release, the next req0 is granted normally.
- Loopback build (SPI_LOOPBACK_EN): send 0xC3 with MISO tied to 0 -> rx_byte=0xC3.
- Withdrawal: req0 pulsed for 1 cycle during GAP of a requester-1 transfer -> no grant0; returns to IDLE and stays with busy=0.
